obi_rr_bank_arbiter: RTL and testbench
======================================

Name: obi_rr_bank_arbiter

Overview:
- N-to-1 OBI arbiter that shares one system-bus slave port (one RAM bank or peripheral port) between several OBI masters.
- Round-robin arbitration with sticky ownership while a request waits for grant.
- Tracks outstanding transactions in an ID FIFO so each variable-latency rvalid/rdata returns to the master that issued it.
- Sits between master-side demux outputs and a slave port of the system bus.

Parameters:
NUM_MASTERS, 4, number of requesting OBI masters (>=2)
MAX_OUTSTANDING, 2, max accepted-but-unanswered transactions (>=1)
IDX_W, $clog2(NUM_MASTERS), master index width (derived, do not override)
CNT_W, $clog2(MAX_OUTSTANDING+1), outstanding counter width (derived, do not override)

Ports:
clk_i  input  1  system clock
rst_ni  input  1  reset; one clock, reset asynchronous active-low
master_req_i  input  obi_req_t[NUM_MASTERS]  master requests (req, we, be[3:0], addr[31:0], wdata[31:0])
master_resp_o  output  obi_resp_t[NUM_MASTERS]  master responses (gnt, rvalid, rdata[31:0])
slave_req_o  output  obi_req_t  request to shared slave
slave_resp_i  input  obi_resp_t  response from shared slave
outstanding_o  output  CNT_W  current outstanding count
proto_err_o  output  1  one-cycle pulse: rvalid received with no outstanding transaction

Behaviour:
- Reset (async assert, sync release): rr_ptr=0, lock_valid=0, FIFO empty, count=0. All master_resp_o=0, slave_req_o=0, outstanding_o=0, proto_err_o=0.
- Arbitration (combinational on current cycle):
  - If lock_valid: winner = lock_idx.
  - Otherwise: winner = first i with master_req_i[i].req, searching rr_ptr, rr_ptr+1, ... modulo NUM_MASTERS.
- Forwarding: slave_req_o = master_req_i[winner] when any req and count<MAX_OUTSTANDING; otherwise slave_req_o='0.
- Grant: master_resp_o[winner].gnt = slave_resp_i.gnt & slave_req_o.req. All other gnt=0. Handshake = that gnt.
- Sticky lock:
  - req forwarded without gnt: lock_valid<=1, lock_idx<=winner.
  - Handshake: lock_valid<=0.
  - Preserves OBI address/data stability at the slave.
  - If a locked master drops req (protocol violation), lock clears next cycle.
- rr_ptr update: on handshake, rr_ptr<=(winner+1) mod NUM_MASTERS. Unchanged otherwise.
- ID FIFO (depth MAX_OUTSTANDING, entries IDX_W): push winner on handshake; pop head on slave_resp_i.rvalid.
- Response routing: rvalid with FIFO non-empty drives master_resp_o[head].rvalid=1 and rdata=slave_resp_i.rdata in the same cycle (zero added latency). Other masters get rvalid=0 and rdata=0.
- Full: count==MAX_OUTSTANDING forces slave_req_o.req=0, even if rvalid pops in the same cycle (no same-cycle push-through). Lock state is held.
- Simultaneous handshake and rvalid (not full): push and pop in the same cycle; count unchanged.
- Same-cycle response to the grant cycle is not possible; rvalid for a transaction arrives >=1 cycle after its gnt.
- rvalid with FIFO empty: no master rvalid, FIFO/count unchanged, proto_err_o=1 for that cycle.
- Counter: count += push - pop. Saturation is impossible by construction. outstanding_o = count (registered).
- Reset mid-operation: outstanding IDs are discarded. Later stray rvalid raises proto_err_o.
- Latency: request path and response path are both combinational. Only state is rr_ptr, lock, FIFO, and count.

Test Plan:
- Single master: M2 read at addr 0x100 with gnt=1, rvalid next cycle with rdata 0xDEADBEEF -> M2 gets gnt in cycle 0 and rvalid/rdata 0xDEADBEEF in cycle 1; others see 0; outstanding_o 1 then 0.
- Round-robin: M0, M1, M3 req continuously, slave always gnt, rvalid at 1 cycle -> grant order M0, M1, M3, M0, M1, M3; rr_ptr after the first grant = 1.
- Sticky lock: M1 req with gnt=0 for 3 cycles, M0 raises req in cycle 1 -> slave_req_o keeps M1 addr for 4 cycles; M1 granted in cycle 3; M0 granted in cycle 4.
- Full/backpressure: MAX_OUTSTANDING=2, two handshakes, rvalid held off -> slave_req_o.req=0 while count=2, including the cycle the first rvalid arrives. Third request forwarded the cycle after the pop. Responses return in order to the issuing masters.
- Push+pop same cycle: count=1, new handshake coincides with rvalid -> rvalid routed to the older ID; outstanding_o stays 1; the next rvalid goes to the new requester.
- Protocol/reset: rvalid with count=0 -> proto_err_o pulses 1 cycle, no master rvalid. Assert rst_ni=0 with count=2 -> all outputs 0 immediately; after release, outstanding_o=0 and rr_ptr=0.

Source files
------------

// File: rtl/obi_rr_bank_arbiter.sv
// N-to-1 OBI arbiter: round-robin with sticky ownership until grant, plus an
// ID FIFO that steers each in-order rvalid/rdata back to the issuing master.
package obi_rr_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module obi_rr_port
  import obi_rr_pkg::*;
(
  input  logic        i_gnt,
  input  logic        i_rsp,
  input  logic [31:0] i_rdata,
  output obi_resp_t   o_resp
);
  assign o_resp.gnt    = i_gnt;
  assign o_resp.rvalid = i_rsp;
  assign o_resp.rdata  = i_rsp ? i_rdata : '0;
endmodule

module obi_rr_bank_arbiter
  import obi_rr_pkg::*;
#(
  parameter  int NUM_MASTERS     = 4,
  parameter  int MAX_OUTSTANDING = 2,
  localparam int IDX_W           = $clog2(NUM_MASTERS),
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  obi_req_t  [NUM_MASTERS-1:0]  master_req_i,
  output obi_resp_t [NUM_MASTERS-1:0]  master_resp_o,
  output obi_req_t                     slave_req_o,
  input  obi_resp_t                    slave_resp_i,
  output logic [CNT_W-1:0]             outstanding_o,
  output logic                         proto_err_o
);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [IDX_W-1:0] r_rr_ptr;
  logic             r_lock_valid;
  logic [IDX_W-1:0] r_lock_idx;
  logic [IDX_W-1:0] r_fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0] r_count;

  logic [NUM_MASTERS-1:0] w_req_vec;
  logic [IDX_W-1:0]       w_cand [NUM_MASTERS];
  logic [IDX_W-1:0]       w_rr_idx, w_winner, w_head;
  logic                   w_full, w_empty, w_fwd, w_hs, w_pop;

  function automatic logic [PTR_W-1:0] f_nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Candidate k is (rr_ptr + k) mod N; sum never exceeds 2N-2, so one subtract suffices.
  for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_cand
    logic [IDX_W:0] w_sum;
    assign w_sum     = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
    assign w_cand[k] = (w_sum >= (IDX_W+1)'(NUM_MASTERS))
                     ? IDX_W'(w_sum - (IDX_W+1)'(NUM_MASTERS)) : w_sum[IDX_W-1:0];
    assign w_req_vec[k] = master_req_i[k].req;
  end

  always_comb begin
    w_rr_idx = r_rr_ptr;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (w_req_vec[w_cand[k]]) w_rr_idx = w_cand[k];
    end
  end

  assign w_winner = r_lock_valid ? r_lock_idx : w_rr_idx;
  assign w_full   = (r_count == CNT_W'(MAX_OUTSTANDING));
  assign w_empty  = (r_count == '0);
  assign w_head   = r_fifo[r_rptr];

  // Outputs are gated by rst_ni so an asserted reset silences them immediately.
  assign w_fwd       = rst_ni && (|w_req_vec) && !w_full;
  assign slave_req_o = w_fwd ? master_req_i[w_winner] : '0;
  assign w_hs        = slave_req_o.req && slave_resp_i.gnt;
  assign w_pop       = rst_ni && slave_resp_i.rvalid && !w_empty;
  assign proto_err_o = rst_ni && slave_resp_i.rvalid && w_empty;
  assign outstanding_o = r_count;

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_port
    obi_rr_port u_port (
      .i_gnt   (w_hs && (w_winner == IDX_W'(g))),
      .i_rsp   (w_pop && (w_head == IDX_W'(g))),
      .i_rdata (slave_resp_i.rdata),
      .o_resp  (master_resp_o[g])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr     <= '0;
      r_lock_valid <= 1'b0;
      r_lock_idx   <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
    end else begin
      if (w_hs)
        r_rr_ptr <= (w_winner == IDX_W'(NUM_MASTERS - 1)) ? '0 : w_winner + IDX_W'(1);
      // Hold the owner until its address phase completes; drop it if it abandons req.
      if (slave_req_o.req && !slave_resp_i.gnt) begin
        r_lock_valid <= 1'b1;
        r_lock_idx   <= w_winner;
      end else if (w_hs) begin
        r_lock_valid <= 1'b0;
      end else if (r_lock_valid && !w_full && !master_req_i[r_lock_idx].req) begin
        r_lock_valid <= 1'b0;
      end
      if (w_hs)  r_wptr <= f_nxt(r_wptr);
      if (w_pop) r_rptr <= f_nxt(r_rptr);
      r_count <= r_count + CNT_W'(w_hs) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_hs) r_fifo[r_wptr] <= w_winner;
  end
endmodule

// File: tb/tb_obi_rr_bank_arbiter.sv
// Directed bench for obi_rr_bank_arbiter: reset, single master, round-robin,
// sticky lock, full backpressure with push+pop, protocol error, mid-run reset.
module tb_obi_rr_bank_arbiter;
  import obi_rr_pkg::*;

  logic                 clk;
  logic                 rst_n;
  obi_req_t  [3:0]      m_req;
  obi_resp_t [3:0]      m_resp;
  obi_req_t             s_req;
  obi_resp_t            s_resp;
  logic [1:0]           outst;
  logic                 perr;

  int n_vec  = 0;
  int n_fail = 0;

  logic [3:0] gnt_v, rv_v;
  always_comb begin
    gnt_v = '0;
    rv_v  = '0;
    for (int i = 0; i < 4; i++) begin
      gnt_v[i] = m_resp[i].gnt;
      rv_v[i]  = m_resp[i].rvalid;
    end
  end

  obi_rr_bank_arbiter #(.NUM_MASTERS(4), .MAX_OUTSTANDING(2)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .master_req_i  (m_req),
    .master_resp_o (m_resp),
    .slave_req_o   (s_req),
    .slave_resp_i  (s_resp),
    .outstanding_o (outst),
    .proto_err_o   (perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] i, input logic [31:0] a);
    m_req[i] = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: a, wdata: 32'h0};
  endtask

  task automatic drop(input logic [1:0] i);
    m_req[i] = '0;
  endtask

  task automatic rsp(input logic g, input logic rv, input logic [31:0] d);
    s_resp = '{gnt: g, rvalid: rv, rdata: d};
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    m_req  = '0;
    s_resp = '0;
    // reset state, with live inputs to prove outputs are gated
    drive(2'd1, 32'h40);
    rsp(1'b1, 1'b1, 32'h1234);
    #2;
    chk("rst_sreq", 32'(s_req != '0), 32'h0);
    chk("rst_gnt",  32'(gnt_v), 32'h0);
    chk("rst_rv",   32'(rv_v), 32'h0);
    chk("rst_perr", 32'(perr), 32'h0);
    chk("rst_out",  32'(outst), 32'h0);
    m_req = '0; s_resp = '0;
    tick;
    rst_n = 1'b1;
    tick;

    // single master
    drive(2'd2, 32'h100); rsp(1'b1, 1'b0, 32'h0); #2;
    chk("s_gnt",  32'(gnt_v), 32'h4);
    chk("s_addr", s_req.addr, 32'h100);
    tick;
    chk("s_out1", 32'(outst), 32'h1);
    drop(2'd2); rsp(1'b0, 1'b1, 32'hDEADBEEF); #2;
    chk("s_rv",    32'(rv_v), 32'h4);
    chk("s_rd2",   m_resp[2].rdata, 32'hDEADBEEF);
    chk("s_rd0",   m_resp[0].rdata, 32'h0);
    chk("s_gnt0",  32'(gnt_v), 32'h0);
    tick;
    chk("s_out0",  32'(outst), 32'h0);
    chk("s_ptr",   32'(dut.r_rr_ptr), 32'h3);

    // round-robin from a fresh reset
    rsp(1'b0, 1'b0, 32'h0);
    rst_n = 1'b0; #2; rst_n = 1'b1;
    drive(2'd0, 32'h10); drive(2'd1, 32'h11); drive(2'd3, 32'h13);
    rsp(1'b1, 1'b0, 32'h0); #2;
    chk("rr_g0", 32'(gnt_v), 32'h1);
    tick;
    chk("rr_ptr1", 32'(dut.r_rr_ptr), 32'h1);
    rsp(1'b1, 1'b1, 32'hA0); #2;
    chk("rr_g1", 32'(gnt_v), 32'h2);
    chk("rr_v1", 32'(rv_v), 32'h1);
    tick;
    rsp(1'b1, 1'b1, 32'hA1); #2;
    chk("rr_g2", 32'(gnt_v), 32'h8);
    chk("rr_v2", 32'(rv_v), 32'h2);
    tick;
    rsp(1'b1, 1'b1, 32'hA3); #2;
    chk("rr_g3", 32'(gnt_v), 32'h1);
    chk("rr_v3", 32'(rv_v), 32'h8);
    chk("rr_d3", m_resp[3].rdata, 32'hA3);
    tick;
    chk("rr_out", 32'(outst), 32'h1);
    rsp(1'b1, 1'b1, 32'hB0); #2;
    chk("rr_g4", 32'(gnt_v), 32'h2);
    tick;
    rsp(1'b1, 1'b1, 32'hB1); #2;
    chk("rr_g5", 32'(gnt_v), 32'h8);
    tick;
    m_req = '0; rsp(1'b0, 1'b1, 32'hB3); #2;
    chk("rr_v6", 32'(rv_v), 32'h8);
    tick;
    chk("rr_out0", 32'(outst), 32'h0);
    chk("rr_ptr0", 32'(dut.r_rr_ptr), 32'h0);

    // sticky lock: M1 held without gnt, M0 arrives later
    drive(2'd1, 32'h200); rsp(1'b0, 1'b0, 32'h0); #2;
    chk("lk_a0", s_req.addr, 32'h200);
    tick;
    drive(2'd0, 32'h300); #2;
    chk("lk_a1", s_req.addr, 32'h200);
    chk("lk_g1", 32'(gnt_v), 32'h0);
    tick;
    #2;
    chk("lk_a2", s_req.addr, 32'h200);
    tick;
    rsp(1'b1, 1'b0, 32'h0); #2;
    chk("lk_a3", s_req.addr, 32'h200);
    chk("lk_g3", 32'(gnt_v), 32'h2);
    tick;
    chk("lk_ptr", 32'(dut.r_rr_ptr), 32'h2);
    drop(2'd1); #2;
    chk("lk_g4", 32'(gnt_v), 32'h1);
    chk("lk_a4", s_req.addr, 32'h300);
    tick;
    m_req = '0; rsp(1'b0, 1'b1, 32'hC1); #2;
    chk("lk_v5", 32'(rv_v), 32'h2);
    tick;
    rsp(1'b0, 1'b1, 32'hC0); #2;
    chk("lk_v6", 32'(rv_v), 32'h1);
    tick;
    chk("lk_out", 32'(outst), 32'h0);

    // full backpressure, then push+pop in one cycle
    drive(2'd2, 32'h400); rsp(1'b1, 1'b0, 32'h0); #2;
    chk("fu_g0", 32'(gnt_v), 32'h4);
    tick;
    drop(2'd2); drive(2'd3, 32'h500); #2;
    chk("fu_g1", 32'(gnt_v), 32'h8);
    tick;
    chk("fu_out2", 32'(outst), 32'h2);
    drop(2'd3); drive(2'd0, 32'h600); #2;
    chk("fu_req2", 32'(s_req.req), 32'h0);
    chk("fu_g2", 32'(gnt_v), 32'h0);
    tick;
    rsp(1'b1, 1'b1, 32'hA); #2;
    chk("fu_req3", 32'(s_req.req), 32'h0);
    chk("fu_v3", 32'(rv_v), 32'h4);
    chk("fu_d3", m_resp[2].rdata, 32'hA);
    tick;
    chk("fu_out3", 32'(outst), 32'h1);
    rsp(1'b1, 1'b1, 32'hB); #2;
    chk("pp_g", 32'(gnt_v), 32'h1);
    chk("pp_a", s_req.addr, 32'h600);
    chk("pp_v", 32'(rv_v), 32'h8);
    chk("pp_d", m_resp[3].rdata, 32'hB);
    tick;
    chk("pp_out", 32'(outst), 32'h1);
    m_req = '0; rsp(1'b0, 1'b1, 32'hC); #2;
    chk("pp_v2", 32'(rv_v), 32'h1);
    chk("pp_d2", m_resp[0].rdata, 32'hC);
    tick;
    chk("pp_out0", 32'(outst), 32'h0);

    // stray rvalid
    rsp(1'b0, 1'b1, 32'hE); #2;
    chk("pe_err", 32'(perr), 32'h1);
    chk("pe_rv",  32'(rv_v), 32'h0);
    tick;
    rsp(1'b0, 1'b0, 32'h0); #2;
    chk("pe_err0", 32'(perr), 32'h0);
    chk("pe_out",  32'(outst), 32'h0);

    // reset with two outstanding
    drive(2'd1, 32'h700); rsp(1'b1, 1'b0, 32'h0); #2;
    chk("mr_g0", 32'(gnt_v), 32'h2);
    tick;
    drop(2'd1); drive(2'd2, 32'h800); #2;
    chk("mr_g1", 32'(gnt_v), 32'h4);
    tick;
    chk("mr_out2", 32'(outst), 32'h2);
    drop(2'd2); drive(2'd3, 32'h900); rsp(1'b1, 1'b1, 32'hF);
    rst_n = 1'b0; #1;
    chk("mr_sreq", 32'(s_req != '0), 32'h0);
    chk("mr_gnt",  32'(gnt_v), 32'h0);
    chk("mr_rv",   32'(rv_v), 32'h0);
    chk("mr_perr", 32'(perr), 32'h0);
    chk("mr_out",  32'(outst), 32'h0);
    m_req = '0; s_resp = '0;
    tick;
    rst_n = 1'b1; #2;
    chk("mr_ptr",  32'(dut.r_rr_ptr), 32'h0);
    chk("mr_out0", 32'(outst), 32'h0);
    rsp(1'b0, 1'b1, 32'h5); #1;
    chk("mr_perr1", 32'(perr), 32'h1);
    chk("mr_rv1",   32'(rv_v), 32'h0);
    tick;
    s_resp = '0;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
